// File: rtl/pipe_stage_buf_pkg.sv
// Shared widths and helpers for the pipe_stage_buf inter-stage buffer.
// Statistics helpers are only referenced when PIPE_STAGE_BUF_STAT_EN is defined.
package pipe_stage_buf_pkg;

    localparam int unsigned DEF_BUS_WD = 64;
    localparam int unsigned DEF_DEPTH  = 2;
    localparam int unsigned STAT_WD    = 32;

    localparam logic [STAT_WD-1:0] STAT_MAX = '1;

    // Saturating event counter step
    function automatic logic [STAT_WD-1:0] sat_inc(input logic [STAT_WD-1:0] v,
                                                   input logic               en);
        return (en && (v != STAT_MAX)) ? v + STAT_WD'(1) : v;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// DEPTH x BUS_WD register array: one synchronous write port, one async read port.
module pipe_buf_mem #(
    parameter int unsigned BUS_WD = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned PTR_WD = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_WD-1:0] waddr,
    input  logic [BUS_WD-1:0] wdata,
    input  logic [PTR_WD-1:0] raddr,
    output logic [BUS_WD-1:0] rdata
);

    logic [BUS_WD-1:0] mem [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the owner's count
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry valid/allowin pipeline buffer with flush; DEPTH=1 is a classic stage register.
// Define PIPE_STAGE_BUF_STAT_EN to add saturating stall_cnt/full_cnt outputs.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned BUS_WD = DEF_BUS_WD,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned CNT_WD = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [BUS_WD-1:0] in_bus,
    output logic              out_valid,
    input  logic              out_allowin,
    output logic [BUS_WD-1:0] out_bus,
`ifdef PIPE_STAGE_BUF_STAT_EN
    output logic [STAT_WD-1:0] stall_cnt,
    output logic [STAT_WD-1:0] full_cnt,
`endif
    output logic [CNT_WD-1:0] occupancy
);

    localparam int unsigned PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_WD-1:0] count;
    logic [PTR_WD-1:0] rd_ptr;
    logic [PTR_WD-1:0] wr_ptr;
    logic [BUS_WD-1:0] rd_data;
    logic              push;
    logic              pop;
    logic              full;

    function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
        return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + PTR_WD'(1);
    endfunction

    assign full       = (count == CNT_WD'(DEPTH));
    assign in_allowin = !full || out_allowin;
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_allowin;
    assign pop        = out_valid && out_allowin;
    assign occupancy  = count;
    // Gate the head so out_bus reads zero whenever nothing is valid (incl. reset)
    assign out_bus    = out_valid ? rd_data : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_WD'(1);
            else if (pop && !push) count <= count - CNT_WD'(1);
        end
    end

    pipe_buf_mem #(
        .BUS_WD (BUS_WD),
        .DEPTH  (DEPTH),
        .PTR_WD (PTR_WD)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (in_bus),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

`ifdef PIPE_STAGE_BUF_STAT_EN
    // Statistics survive flush; only reset clears them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            full_cnt  <= '0;
        end else begin
            stall_cnt <= sat_inc(stall_cnt, out_valid && !out_allowin);
            full_cnt  <= sat_inc(full_cnt, full);
        end
    end
`endif

    always @(posedge clk) begin
        if (resetn) begin
            assert (count <= CNT_WD'(DEPTH))
                else $error("pipe_stage_buf: count %0d above DEPTH %0d", count, DEPTH);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf (DEPTH=2 and DEPTH=3 instances).
// Statistics checks compile in when PIPE_STAGE_BUF_STAT_EN is defined.
module tb_pipe_stage_buf;
    import pipe_stage_buf_pkg::*;

    localparam int unsigned BW = 64;

    logic clk = 1'b0;
    logic resetn;

    logic          a_flush, a_in_valid, a_in_allowin, a_out_valid, a_out_allowin;
    logic [BW-1:0] a_in_bus, a_out_bus;
    logic [1:0]    a_occ;
    logic          b_flush, b_in_valid, b_in_allowin, b_out_valid, b_out_allowin;
    logic [BW-1:0] b_in_bus, b_out_bus;
    logic [1:0]    b_occ;
`ifdef PIPE_STAGE_BUF_STAT_EN
    logic [STAT_WD-1:0] a_stall_cnt, a_full_cnt, b_stall_cnt, b_full_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.BUS_WD(BW), .DEPTH(2)) u_dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (a_flush),
        .in_valid    (a_in_valid),
        .in_allowin  (a_in_allowin),
        .in_bus      (a_in_bus),
        .out_valid   (a_out_valid),
        .out_allowin (a_out_allowin),
        .out_bus     (a_out_bus),
`ifdef PIPE_STAGE_BUF_STAT_EN
        .stall_cnt   (a_stall_cnt),
        .full_cnt    (a_full_cnt),
`endif
        .occupancy   (a_occ)
    );

    pipe_stage_buf #(.BUS_WD(BW), .DEPTH(3)) u_dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (b_flush),
        .in_valid    (b_in_valid),
        .in_allowin  (b_in_allowin),
        .in_bus      (b_in_bus),
        .out_valid   (b_out_valid),
        .out_allowin (b_out_allowin),
        .out_bus     (b_out_bus),
`ifdef PIPE_STAGE_BUF_STAT_EN
        .stall_cnt   (b_stall_cnt),
        .full_cnt    (b_full_cnt),
`endif
        .occupancy   (b_occ)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
            end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rx;
        int next_tx;
        int cycles;
        logic do_push, do_pop;

        resetn = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_allowin = 1'b0; a_in_bus = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_allowin = 1'b0; b_in_bus = '0;
        #2;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_occ",       64'(a_occ),       64'd0);
        check("rst_out_bus",   a_out_bus,        64'd0);
        tick(); tick();
        resetn = 1'b1;

        // Fill DEPTH=2 with downstream stalled
        a_in_valid = 1'b1; a_in_bus = 64'h11;
        #1 check("fill_allowin0", 64'(a_in_allowin), 64'd1);
        tick();
        check("fill_occ1",  64'(a_occ),     64'd1);
        check("fill_head1", a_out_bus,      64'h11);
        a_in_bus = 64'h22;
        tick();
        check("fill_occ2",    64'(a_occ),        64'd2);
        check("fill_allowin", 64'(a_in_allowin), 64'd0);
        check("fill_head2",   a_out_bus,         64'h11);

        // Full: simultaneous push and pop
        a_in_bus = 64'h33; a_out_allowin = 1'b1;
        #1 check("pp_allowin", 64'(a_in_allowin), 64'd1);
        tick();
        check("pp_occ",   64'(a_occ), 64'd2);
        check("pp_head2", a_out_bus,  64'h22);
        a_in_valid = 1'b0;
        tick();
        check("pp_occ1",  64'(a_occ), 64'd1);
        check("pp_head3", a_out_bus,  64'h33);

        // Refill to 2 entries, then flush with a competing push
        a_out_allowin = 1'b0; a_in_valid = 1'b1; a_in_bus = 64'h55;
        tick();
        check("fl_occ_pre", 64'(a_occ), 64'd2);
        a_flush = 1'b1; a_out_allowin = 1'b1; a_in_bus = 64'h44;
        #1 check("fl_allowin", 64'(a_in_allowin), 64'd1);
        tick();
        check("fl_out_valid", 64'(a_out_valid), 64'd0);
        check("fl_occ",       64'(a_occ),       64'd0);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_allowin = 1'b0;
        tick();
        check("fl_dropped", 64'(a_out_valid), 64'd0);

        // Async reset mid-stream with two entries held
        a_in_valid = 1'b1; a_in_bus = 64'h77;
        tick();
        a_in_bus = 64'h88;
        tick();
        a_in_valid = 1'b0;
        check("ar_occ_pre", 64'(a_occ), 64'd2);
        #2 resetn = 1'b0;
        #1;
        check("ar_out_valid", 64'(a_out_valid), 64'd0);
        check("ar_occ",       64'(a_occ),       64'd0);
        check("ar_out_bus",   a_out_bus,        64'd0);
        tick();
        #2 resetn = 1'b1;
        a_in_valid = 1'b1; a_in_bus = 64'h99;
        tick();
        a_in_valid = 1'b0;
        check("ar_post_occ",  64'(a_occ), 64'd1);
        check("ar_post_head", a_out_bus,  64'h99);

`ifdef PIPE_STAGE_BUF_STAT_EN
        // Five stalled cycles, then a flush that pops rather than stalls
        repeat (5) tick();
        check("st_stall5", 64'(a_stall_cnt), 64'd5);
        check("st_full0",  64'(a_full_cnt),  64'd0);
        a_flush = 1'b1; a_out_allowin = 1'b1;
        tick();
        a_flush = 1'b0; a_out_allowin = 1'b0;
        tick();
        check("st_after_flush", 64'(a_stall_cnt), 64'd5);
        check("st_flush_empty", 64'(a_out_valid), 64'd0);
`endif

        // DEPTH=3 wrap: stream 1..10 with random back-pressure
        exp_rx  = 1;
        next_tx = 1;
        cycles  = 0;
        while (exp_rx <= 10 && cycles < 500) begin
            b_in_valid    = (next_tx <= 10);
            b_in_bus      = 64'(next_tx);
            b_out_allowin = 1'($urandom_range(0, 1));
            #1;
            do_push = b_in_valid && b_in_allowin;
            do_pop  = b_out_valid && b_out_allowin;
            if (do_pop) begin
                check("wrap_order", b_out_bus, 64'(exp_rx));
                exp_rx++;
            end
            tick();
            if (do_push) next_tx++;
            cycles++;
        end
        b_in_valid = 1'b0; b_out_allowin = 1'b0;
        check("wrap_all_rx", 64'(exp_rx), 64'd11);
        #1 check("wrap_empty", 64'(b_occ), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
